i2c_oled_target: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_oled_target.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_oled_target.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the SSD1306-style master/target pair:
// FSM encoding, ACK levels, control-byte bit positions and default address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_PAYLOAD,
    ST_PAYLOAD_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam int         CO_BIT       = 7;
  localparam int         DC_BIT       = 6;
  localparam logic [6:0] DEFAULT_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the CLK domain and flags SCL edges plus
// START/STOP conditions, one register past the synchronizer chain.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl       = scl_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl & ~scl_prev_q;
  assign scl_fall  = ~scl &  scl_prev_q;
  assign start_det =  scl &  scl_prev_q &  sda_prev_q & ~sda;
  assign stop_det  =  scl &  scl_prev_q & ~sda_prev_q &  sda;

endmodule

// File: rtl/i2c_oled_target.sv
// SSD1306-style I2C target: decodes control bytes, ACKs every matched write
// byte, strobes payload bytes tagged command/data, and answers reads with status.
module i2c_oled_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] status,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det, bus_cond;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d;
  logic [7:0] shift_q, shift_d;
  logic       co_q, co_d, dc_q, dc_d, rw_q, rw_d, mack_q, mack_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic       byte_valid_q, byte_valid_d, byte_is_data_q, byte_is_data_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] byte_data_q, byte_data_d;

  assign bus_cond = start_det | stop_det;

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    full_d         = full_q;
    shift_d        = shift_q;
    co_d           = co_q;
    dc_d           = dc_q;
    rw_d           = rw_q;
    mack_d         = mack_q;
    sda_oe_d       = sda_oe_q;
    busy_d         = busy_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    frame_start_d  = 1'b0;

    if (bus_cond) begin
      state_d   = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_CTRL, ST_PAYLOAD: begin
          if (scl_rise && !full_q) begin
            shift_d   = {shift_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 3'd1;
            full_d    = (bit_cnt_q == 3'd7);
            if (state_q == ST_PAYLOAD && bit_cnt_q == 3'd7) begin
              byte_valid_d   = 1'b1;
              byte_data_d    = {shift_q[6:0], sda};
              byte_is_data_d = dc_q;
            end
          end else if (scl_fall && full_q) begin
            // Byte complete: the ACK slot opens on this SCL falling edge.
            full_d = 1'b0;
            unique case (state_q)
              ST_ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  state_d       = ST_ADDR_ACK;
                  rw_d          = shift_q[0];
                  sda_oe_d      = 1'b1;
                  frame_start_d = 1'b1;
                  busy_d        = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end
              ST_CTRL: begin
                state_d  = ST_CTRL_ACK;
                co_d     = shift_q[CO_BIT];
                dc_d     = shift_q[DC_BIT];
                sda_oe_d = 1'b1;
              end
              default: begin
                state_d  = ST_PAYLOAD_ACK;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_CTRL_ACK, ST_PAYLOAD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            unique case (state_q)
              ST_ADDR_ACK: begin
                if (rw_q) begin
                  state_d  = ST_READ;
                  shift_d  = status;
                  sda_oe_d = ~status[7];
                end else begin
                  state_d = ST_CTRL;
                end
              end
              ST_CTRL_ACK: state_d = ST_PAYLOAD;
              default:     state_d = co_q ? ST_CTRL : ST_PAYLOAD;
            endcase
          end
        end
        ST_READ: begin
          if (scl_rise && !full_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            full_d    = (bit_cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (full_q) begin
              full_d   = 1'b0;
              state_d  = ST_READ_ACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            mack_d = sda;
          end else if (scl_fall) begin
            if (mack_q == NACK) begin
              state_d = ST_IGNORE;
            end else begin
              state_d  = ST_READ;
              shift_d  = status;
              sda_oe_d = ~status[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 3'd0;
      full_q         <= 1'b0;
      shift_q        <= 8'h00;
      co_q           <= 1'b0;
      dc_q           <= 1'b0;
      rw_q           <= 1'b0;
      mack_q         <= 1'b0;
      sda_oe_q       <= 1'b0;
      busy_q         <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      full_q         <= full_d;
      shift_q        <= shift_d;
      co_q           <= co_d;
      dc_q           <= dc_d;
      rw_q           <= rw_d;
      mack_q         <= mack_d;
      sda_oe_q       <= sda_oe_d;
      busy_q         <= busy_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // START/STOP release SDA and close the frame in the detection cycle itself.
  assign sda_oe       = sda_oe_q & ~bus_cond;
  assign frame_end    = busy_q & bus_cond;
  assign busy         = busy_q & ~bus_cond;
  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_i2c_oled_target.sv
// Bench for i2c_oled_target: a bit-banged I2C master on a wired-AND SDA line,
// with a scoreboard queue of expected payload strobes.
module tb_i2c_oled_target;
  import i2c_pkg::*;

  localparam int Q = 8;  // CLK cycles per quarter SCL period

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] status = 8'h00;
  logic       sda_line;
  logic       sda_oe, byte_valid, byte_is_data, frame_start, frame_end, busy;
  logic [7:0] byte_data;

  assign sda_line = sda_m & ~sda_oe;

  always #5 CLK = ~CLK;

  i2c_oled_target dut (
    .CLK          (CLK),
    .RST          (RST),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .status       (status),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .busy         (busy)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         fs_cnt = 0, fe_cnt = 0, bv_cnt = 0, viol_cnt = 0;
  logic       oe_seen = 1'b0;
  logic       oe_prev = 1'b0;
  logic       scl_prev = 1'b1;
  logic [8:0] exp_q[$];

  // Monitor: strobe counters, scoreboard pops, and SDA changes while SCL is high.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (!RST) begin
      if (frame_start) fs_cnt++;
      if (frame_end) fe_cnt++;
      if (sda_oe) oe_seen = 1'b1;
      if (scl_m && scl_prev && sda_oe !== oe_prev) viol_cnt++;
      if (byte_valid) begin
        bv_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL byte_valid_unexpected: got is_data=%b data=%02h, none expected",
                   byte_is_data, byte_data);
        end else begin
          e = exp_q.pop_front();
          if ({byte_is_data, byte_data} !== e)
            $display("FAIL payload: got is_data=%b data=%02h, want is_data=%b data=%02h",
                     byte_is_data, byte_data, e[8], e[7:0]);
          else
            pass_cnt++;
        end
      end
    end
    oe_prev  = sda_oe;
    scl_prev = scl_m;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
  endtask

  task automatic write_frame(input logic [7:0] bytes[$], output logic acks[$]);
    logic a;
    acks = {};
    i2c_start;
    foreach (bytes[i]) begin
      write_byte(bytes[i], a);
      acks.push_back(a);
    end
    i2c_stop;
    wait_clk(4 * Q);
  endtask

  task automatic test_reset;
    wait_clk(5);
    total_cnt += 7;
    if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else pass_cnt++;
    if (byte_valid !== 1'b0) $display("FAIL reset_byte_valid: got %b want 0", byte_valid); else pass_cnt++;
    if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start); else pass_cnt++;
    if (frame_end !== 1'b0) $display("FAIL reset_frame_end: got %b want 0", frame_end); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    if (byte_data !== 8'h00) $display("FAIL reset_byte_data: got %02h want 00", byte_data); else pass_cnt++;
    if (byte_is_data !== 1'b0) $display("FAIL reset_byte_is_data: got %b want 0", byte_is_data); else pass_cnt++;
    RST = 1'b0;
    wait_clk(4 * Q);
  endtask

  // Runs one write frame and checks ACKs plus strobe/frame counts.
  task automatic test_write(input string name, input logic [7:0] bytes[$], input int exp_bv);
    logic acks[$];
    int   fs0, fe0, bv0;
    fs0 = fs_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
    write_frame(bytes, acks);
    foreach (acks[i]) begin
      total_cnt++;
      if (acks[i] !== ACK) $display("FAIL %s_ack[%0d]: got %b want 0", name, i, acks[i]);
      else pass_cnt++;
    end
    total_cnt += 4;
    if (bv_cnt - bv0 != exp_bv) $display("FAIL %s_strobes: got %0d want %0d", name, bv_cnt - bv0, exp_bv); else pass_cnt++;
    if (fs_cnt - fs0 != 1) $display("FAIL %s_frame_start: got %0d want 1", name, fs_cnt - fs0); else pass_cnt++;
    if (fe_cnt - fe0 != 1) $display("FAIL %s_frame_end: got %0d want 1", name, fe_cnt - fe0); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", name, busy); else pass_cnt++;
  endtask

  task automatic test_cmd_write;
    exp_q.push_back({1'b0, 8'hAE});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'h80});
    test_write("cmd", '{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80}, 3);
  endtask

  task automatic test_data_write;
    exp_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b1, 8'h0F});
    test_write("data", '{8'h78, 8'h40, 8'hFF, 8'h0F}, 2);
  endtask

  task automatic test_co_write;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, 8'h3C});
    test_write("co", '{8'h78, 8'h80, 8'hA5, 8'hC0, 8'h3C}, 2);
  endtask

  task automatic test_control_only;
    test_write("ctrl_only", '{8'h78, 8'h00}, 0);
  endtask

  task automatic test_wrong_addr;
    logic a0, a1;
    int   fs0, bv0;
    fs0 = fs_cnt; bv0 = bv_cnt;
    oe_seen = 1'b0;
    i2c_start;
    write_byte(8'h7A, a0);
    write_byte(8'h00, a1);
    i2c_stop;
    wait_clk(4 * Q);
    total_cnt += 4;
    if (a0 !== NACK) $display("FAIL wrong_addr_ack: got %b want 1", a0); else pass_cnt++;
    if (oe_seen !== 1'b0) $display("FAIL wrong_addr_sda_oe: got %b want 0", oe_seen); else pass_cnt++;
    if (fs_cnt != fs0) $display("FAIL wrong_addr_frame_start: got %0d want 0", fs_cnt - fs0); else pass_cnt++;
    if (bv_cnt != bv0) $display("FAIL wrong_addr_strobes: got %0d want 0", bv_cnt - bv0); else pass_cnt++;
  endtask

  task automatic test_read;
    logic       a;
    logic [7:0] d0, d1;
    int         fe0;
    fe0 = fe_cnt;
    status = 8'h5A;
    i2c_start;
    write_byte(8'h79, a);
    read_byte(d0);
    write_bit(ACK);
    read_byte(d1);
    write_bit(NACK);
    wait_clk(2 * Q);
    total_cnt += 6;
    if (a !== ACK) $display("FAIL read_addr_ack: got %b want 0", a); else pass_cnt++;
    if (d0 !== 8'h5A) $display("FAIL read_byte0: got %02h want 5a", d0); else pass_cnt++;
    if (d1 !== 8'h5A) $display("FAIL read_byte1: got %02h want 5a", d1); else pass_cnt++;
    if (sda_oe !== 1'b0) $display("FAIL read_release: got %b want 0", sda_oe); else pass_cnt++;
    if (busy !== 1'b1) $display("FAIL read_busy: got %b want 1", busy); else pass_cnt++;
    i2c_stop;
    wait_clk(4 * Q);
    if (fe_cnt - fe0 != 1) $display("FAIL read_frame_end: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
  endtask

  task automatic test_partial_stop;
    logic a0, a1;
    int   fe0, bv0;
    fe0 = fe_cnt; bv0 = bv_cnt;
    i2c_start;
    write_byte(8'h78, a0);
    write_byte(8'h40, a1);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop;
    wait_clk(4 * Q);
    total_cnt += 4;
    if (bv_cnt != bv0) $display("FAIL partial_strobes: got %0d want 0", bv_cnt - bv0); else pass_cnt++;
    if (sda_oe !== 1'b0) $display("FAIL partial_sda_oe: got %b want 0", sda_oe); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL partial_busy: got %b want 0", busy); else pass_cnt++;
    if (fe_cnt - fe0 != 1) $display("FAIL partial_frame_end: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
  endtask

  task automatic test_reset_in_ack;
    logic       a0, a1, a2;
    logic [7:0] pb;
    int         fe0;
    pb = 8'hAE;
    exp_q.push_back({1'b0, 8'hAE});
    i2c_start;
    write_byte(8'h78, a0);
    write_byte(8'h00, a1);
    for (int i = 7; i >= 0; i--) write_bit(pb[i]);
    total_cnt++;
    if (sda_oe !== 1'b1) $display("FAIL rst_ack_driven: got %b want 1", sda_oe); else pass_cnt++;
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    total_cnt += 2;
    if (sda_oe !== 1'b0) $display("FAIL rst_release: got %b want 0", sda_oe); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    fe0 = fe_cnt;
    oe_seen = 1'b0;
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    write_byte(8'h11, a2);
    i2c_stop;
    wait_clk(4 * Q);
    total_cnt += 3;
    if (a2 !== NACK) $display("FAIL rst_ignore_ack: got %b want 1", a2); else pass_cnt++;
    if (oe_seen !== 1'b0) $display("FAIL rst_ignore_sda_oe: got %b want 0", oe_seen); else pass_cnt++;
    if (fe_cnt != fe0) $display("FAIL rst_frame_end: got %0d want 0", fe_cnt - fe0); else pass_cnt++;
    exp_q.push_back({1'b0, 8'h11});
    test_write("recover", '{8'h78, 8'h00, 8'h11}, 1);
  endtask

  initial begin
    test_reset;
    test_cmd_write;
    test_data_write;
    test_co_write;
    test_control_only;
    test_wrong_addr;
    test_read;
    test_partial_stop;
    test_reset_in_ack;
    total_cnt += 2;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); else pass_cnt++;
    if (viol_cnt != 0) $display("FAIL sda_change_scl_high: got %0d want 0", viol_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
